// File: rtl/gpio_v2_pkg.sv
// Shared register map, ID signature and address decode for the gpio_v2 register block.
package gpio_v2_pkg;

    localparam logic [11:0] AddrSwDb    = 12'h004;
    localparam logic [11:0] AddrLeds    = 12'h008;
    localparam logic [11:0] AddrHex0    = 12'h00C;
    localparam logic [11:0] AddrIrqEn   = 12'h040;
    localparam logic [11:0] AddrIrqStat = 12'h044;
    localparam logic [11:0] AddrId      = 12'h048;
    localparam logic [7:0]  IdSig       = 8'h47;

    typedef enum logic [2:0] {
        RegNone,
        RegSwDb,
        RegLeds,
        RegHex,
        RegIrqEn,
        RegIrqStat,
        RegId
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [2:0] idx;
    } reg_dec_t;

    // Word-granular decode; HEX slots at or beyond num_hex fall through to RegNone.
    function automatic reg_dec_t decode_addr(input logic [11:0] addr, input int unsigned num_hex);
        logic [9:0] word;
        logic [9:0] hex_word;
        reg_dec_t   dec;
        word     = addr[11:2];
        hex_word = word - AddrHex0[11:2];
        dec.sel  = RegNone;
        dec.idx  = 3'd0;
        if (word == AddrSwDb[11:2]) begin
            dec.sel = RegSwDb;
        end else if (word == AddrLeds[11:2]) begin
            dec.sel = RegLeds;
        end else if (word == AddrIrqEn[11:2]) begin
            dec.sel = RegIrqEn;
        end else if (word == AddrIrqStat[11:2]) begin
            dec.sel = RegIrqStat;
        end else if (word == AddrId[11:2]) begin
            dec.sel = RegId;
        end else if (word >= AddrHex0[11:2] && 32'(hex_word) < num_hex) begin
            dec.sel = RegHex;
            dec.idx = hex_word[2:0];
        end
        return dec;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Switch synchroniser plus tick-paced two-sample debounce filter with rising-edge pulses.
module gpio_debounce #(
    parameter int unsigned SW_W    = 10,
    parameter int unsigned DB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_i,
    output logic [SW_W-1:0] db_o,
    output logic [SW_W-1:0] rise_o
);

    localparam int unsigned CntW = $clog2(DB_TICK);

    logic [SW_W-1:0] sync1_q, sync2_q, prev_q, db_q, db_d;
    logic [CntW-1:0] cnt_q;
    logic            tick;

    assign tick = (cnt_q == CntW'(DB_TICK - 1));

    // A bit only follows the input when two consecutive tick samples agree.
    always_comb begin
        db_d = db_q;
        if (tick) begin
            db_d = (~(sync2_q ^ prev_q) & sync2_q) | ((sync2_q ^ prev_q) & db_q);
        end
    end

    assign rise_o = db_d & ~db_q;
    assign db_o   = db_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            cnt_q   <= tick ? '0 : cnt_q + CntW'(1);
            if (tick) begin
                prev_q <= sync2_q;
            end
            db_q <= db_d;
        end
    end

endmodule

// File: rtl/gpio_v2.sv
// Memory-mapped GPIO block: LEDs, 7-segment digits, debounced switches and a level interrupt.
module gpio_v2
    import gpio_v2_pkg::*;
#(
    parameter int unsigned NUM_HEX = 6,
    parameter int unsigned LED_W   = 8,
    parameter int unsigned SW_W    = 10,
    parameter int unsigned DB_TICK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CS,
    input  logic                 REN,
    input  logic                 WEN,
    input  logic [11:0]          Addr,
    input  logic [31:0]          DataIn,
    output logic [31:0]          DataOut,
    input  logic [SW_W-1:0]      SW,
    output logic [7*NUM_HEX-1:0] HEX,
    output logic [LED_W-1:0]     LEDS,
    output logic                 IRQ
);

    logic [LED_W-1:0]         leds_q;
    logic [NUM_HEX-1:0][6:0]  hex_q;
    logic [SW_W-1:0]          irq_en_q, irq_stat_q;
    logic [31:0]              data_out_q, rdata;
    logic                     irq_q;
    logic [SW_W-1:0]          sw_db, sw_rise, w1c;
    logic                     wr, rd;
    reg_dec_t                 dec;
    logic                     unused_bits;

    assign unused_bits = ^{DataIn, Addr[1:0]};

    gpio_debounce #(
        .SW_W   (SW_W),
        .DB_TICK(DB_TICK)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .sw_i  (SW),
        .db_o  (sw_db),
        .rise_o(sw_rise)
    );

    assign dec = decode_addr(Addr, NUM_HEX);
    assign wr  = CS & WEN;
    assign rd  = CS & REN;

    always_comb begin
        rdata = '0;
        w1c   = '0;
        case (dec.sel)
            RegSwDb:    rdata[SW_W-1:0]  = sw_db;
            RegLeds:    rdata[LED_W-1:0] = leds_q;
            RegHex:     rdata[6:0]       = hex_q[dec.idx];
            RegIrqEn:   rdata[SW_W-1:0]  = irq_en_q;
            RegIrqStat: rdata[SW_W-1:0]  = irq_stat_q;
            RegId:      rdata = {IdSig, 8'(NUM_HEX), 8'(LED_W), 8'(SW_W)};
            default:    rdata = '0;
        endcase
        if (wr && dec.sel == RegIrqStat) begin
            w1c = DataIn[SW_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q     <= '0;
            hex_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            data_out_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr) begin
                case (dec.sel)
                    RegLeds:  leds_q         <= DataIn[LED_W-1:0];
                    RegHex:   hex_q[dec.idx] <= DataIn[6:0];
                    RegIrqEn: irq_en_q       <= DataIn[SW_W-1:0];
                    default:  ;
                endcase
            end
            // New edges are OR-ed in after the clear so a coincident set survives.
            irq_stat_q <= (irq_stat_q & ~w1c) | sw_rise;
            irq_q      <= |(irq_stat_q & irq_en_q);
            if (rd) begin
                data_out_q <= rdata;
            end
        end
    end

    assign DataOut = data_out_q;
    assign HEX     = hex_q;
    assign LEDS    = leds_q;
    assign IRQ     = irq_q;

endmodule

// File: tb/tb_gpio_v2.sv
// Self-checking bench for gpio_v2: register vectors, randomized bus traffic, debounce/IRQ sequences.
module tb_gpio_v2;

    localparam int unsigned NUM_HEX = 6;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned SW_W    = 10;
    localparam int unsigned DB_TICK = 16;

    localparam logic [31:0] ID_EXP   = {8'h47, 8'(NUM_HEX), 8'(LED_W), 8'(SW_W)};
    localparam logic [31:0] LED_MASK = 32'((64'd1 << LED_W) - 1);
    localparam logic [31:0] SW_MASK  = 32'((64'd1 << SW_W) - 1);

    localparam logic [11:0] A_SWDB = 12'h004;
    localparam logic [11:0] A_LEDS = 12'h008;
    localparam logic [11:0] A_HEX0 = 12'h00C;
    localparam logic [11:0] A_EN   = 12'h040;
    localparam logic [11:0] A_STAT = 12'h044;
    localparam logic [11:0] A_ID   = 12'h048;

    logic                 clk = 1'b0;
    logic                 rst, CS, REN, WEN, IRQ;
    logic [11:0]          Addr;
    logic [31:0]          DataIn, DataOut;
    logic [SW_W-1:0]      SW;
    logic [7*NUM_HEX-1:0] HEX;
    logic [LED_W-1:0]     LEDS;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_leds, m_en, m_stat, m_swdb, m_dout;
    logic [6:0]  m_hex[8];

    gpio_v2 #(
        .NUM_HEX(NUM_HEX),
        .LED_W  (LED_W),
        .SW_W   (SW_W),
        .DB_TICK(DB_TICK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .CS     (CS),
        .REN    (REN),
        .WEN    (WEN),
        .Addr   (Addr),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .SW     (SW),
        .HEX    (HEX),
        .LEDS   (LEDS),
        .IRQ    (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] dout;
        logic [31:0] leds;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        CS = 1'b0; REN = 1'b0; WEN = 1'b0;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        CS = 1'b1; WEN = 1'b1; REN = 1'b0; Addr = a; DataIn = d;
        cyc();
        bus_idle();
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        CS = 1'b1; REN = 1'b1; WEN = 1'b0; Addr = a;
        cyc();
        bus_idle();
        d = DataOut;
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        m_leds = '0; m_en = '0; m_stat = '0; m_swdb = '0; m_dout = '0;
        for (int i = 0; i < 8; i++) m_hex[i] = '0;
    endtask

    // Register file seen as an address -> value map.
    function automatic logic [31:0] mread(input logic [11:0] a);
        int w;
        w = int'(a >> 2);
        if (w == 1) return m_swdb;
        if (w == 2) return m_leds;
        if (w >= 3 && w < 3 + int'(NUM_HEX)) return 32'(m_hex[w-3]);
        if (w == 16) return m_en;
        if (w == 17) return m_stat;
        if (w == 18) return ID_EXP;
        return 32'h0;
    endfunction

    function automatic void mwrite(input logic [11:0] a, input logic [31:0] d);
        int w;
        w = int'(a >> 2);
        if (w == 2) m_leds = d & LED_MASK;
        if (w >= 3 && w < 3 + int'(NUM_HEX)) m_hex[w-3] = d[6:0];
        if (w == 16) m_en = d & SW_MASK;
        if (w == 17) m_stat = m_stat & ~d;
    endfunction

    function automatic logic [63:0] hex_model();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_HEX); i++) v = v | (64'(m_hex[i]) << (7 * i));
        return v;
    endfunction

    // Raise SW[0] at a fixed phase after reset; optionally fire a W1C after w1c_at cycles.
    task automatic edge_run(input bit with_w1c, input int w1c_at, output int lat);
        SW = '0;
        do_reset();
        bus_write(A_EN, 32'h1);
        SW[0] = 1'b1;
        lat = 0;
        if (!with_w1c) begin
            while (!IRQ && lat < 4 * int'(DB_TICK)) begin
                cyc();
                lat++;
            end
        end else begin
            repeat (w1c_at) cyc();
            CS = 1'b1; WEN = 1'b1; Addr = A_STAT; DataIn = 32'h1;
            cyc();
            bus_idle();
            lat = w1c_at + 1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int n, lat1, lat2;

        vecs[0]  = '{1'b1, 1'b0, A_LEDS,        32'h0000_00A5, 32'h0000_0000, 32'hA5};
        vecs[1]  = '{1'b0, 1'b1, A_LEDS,        32'h0,         32'h0000_00A5, 32'hA5};
        vecs[2]  = '{1'b1, 1'b0, 12'h020,       32'h0000_007F, 32'h0000_00A5, 32'hA5};
        vecs[3]  = '{1'b0, 1'b1, 12'h020,       32'h0,         32'h0000_007F, 32'hA5};
        vecs[4]  = '{1'b1, 1'b0, 12'h024,       32'h0000_007F, 32'h0000_007F, 32'hA5};
        vecs[5]  = '{1'b0, 1'b1, 12'h024,       32'h0,         32'h0000_0000, 32'hA5};
        vecs[6]  = '{1'b0, 1'b1, A_ID,          32'h0,         32'h4706_080A, 32'hA5};
        vecs[7]  = '{1'b1, 1'b0, A_LEDS,        32'hFFFF_FF3C, 32'h4706_080A, 32'h3C};
        vecs[8]  = '{1'b1, 1'b1, A_LEDS,        32'h0000_0011, 32'h0000_003C, 32'h11};
        vecs[9]  = '{1'b0, 1'b1, 12'h100,       32'h0,         32'h0000_0000, 32'h11};
        vecs[10] = '{1'b0, 1'b1, 12'h030,       32'h0,         32'h0000_0000, 32'h11};
        vecs[11] = '{1'b1, 1'b0, A_EN,          32'hFFFF_FFFF, 32'h0000_0000, 32'h11};
        vecs[12] = '{1'b0, 1'b1, 12'h041,       32'h0,         32'h0000_03FF, 32'h11};
        vecs[13] = '{1'b1, 1'b0, A_EN,          32'h0,         32'h0000_03FF, 32'h11};
        vecs[14] = '{1'b0, 1'b1, A_EN,          32'h0,         32'h0000_0000, 32'h11};
        vecs[15] = '{1'b0, 1'b1, A_STAT,        32'h0,         32'h0000_0000, 32'h11};
        vecs[16] = '{1'b0, 1'b1, A_SWDB,        32'h0,         32'h0000_0000, 32'h11};
        vecs[17] = '{1'b1, 1'b0, A_ID,          32'hFFFF_FFFF, 32'h0000_0000, 32'h11};
        vecs[18] = '{1'b0, 1'b1, A_ID,          32'h0,         32'h4706_080A, 32'h11};

        SW = '0; Addr = '0; DataIn = '0;
        do_reset();
        chk("reset_dout", DataOut, 32'h0);
        chk("reset_leds", LEDS, 0);
        chk("reset_hex", HEX, 0);
        chk("reset_irq", IRQ, 0);

        for (int i = 0; i < 19; i++) begin
            CS = 1'b1; WEN = vecs[i].wr; REN = vecs[i].rd;
            Addr = vecs[i].addr; DataIn = vecs[i].data;
            cyc();
            bus_idle();
            chk($sformatf("vec%0d_dout", i), DataOut, vecs[i].dout);
            chk($sformatf("vec%0d_leds", i), LEDS, vecs[i].leds);
        end
        chk("hex5_port", HEX, 64'h7F << 35);

        // Randomized register traffic against the address-map model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int s, kind;
            logic [11:0] a;
            logic [31:0] d, exp_rd;
            s = int'($urandom_range(0, 13));
            case (s)
                0:  a = A_SWDB;
                1:  a = A_LEDS;
                10: a = A_EN;
                11: a = A_STAT;
                12: a = A_ID;
                13: a = 12'(32'h04C + 4 * $urandom_range(0, 900));
                default: a = 12'(32'(A_HEX0) + 4 * (s - 2));
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            d = $urandom;
            kind = int'($urandom_range(0, 2));
            exp_rd = mread(a);
            CS = 1'b1; WEN = (kind != 1); REN = (kind != 0); Addr = a; DataIn = d;
            cyc();
            bus_idle();
            if (kind != 0) m_dout = exp_rd;
            if (kind != 1) mwrite(a, d);
            chk("rnd_dout", DataOut, m_dout);
            chk("rnd_leds", LEDS, m_leds);
            chk("rnd_hex", HEX, hex_model());
            chk("rnd_irq", IRQ, 0);
        end

        // Switch held from reset: debounced value may not appear before two tick periods.
        SW = '0;
        SW[0] = 1'b1;
        do_reset();
        CS = 1'b1; REN = 1'b1; Addr = A_SWDB;
        n = 0;
        while (DataOut[0] !== 1'b1 && n < 4 * int'(DB_TICK)) begin
            cyc();
            n++;
        end
        bus_idle();
        chk("db_first_not_early", n >= 2 * int'(DB_TICK), 1);
        chk("db_first_in_time", n <= 3 * int'(DB_TICK), 1);
        if (n < 3 * int'(DB_TICK)) repeat (3 * int'(DB_TICK) - n) cyc();
        bus_read(A_SWDB, rd);
        chk("swdb_after_hold", rd, 32'h1);
        bus_read(A_STAT, rd);
        chk("stat_after_hold", rd, 32'h1);
        chk("irq_disabled", IRQ, 0);
        bus_write(A_EN, 32'h1);
        chk("irq_en_same_edge", IRQ, 0);
        cyc();
        chk("irq_en_next", IRQ, 1);

        // Short bursts on SW[1]: every high interval is narrower than one tick period.
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 15)) cyc();
            for (int t = 0; t < 4; t++) begin
                SW[1] = ~SW[1];
                repeat (3) cyc();
            end
            repeat (DB_TICK) cyc();
        end
        repeat (2 * DB_TICK) cyc();
        bus_read(A_SWDB, rd);
        chk("bounce_swdb", rd, 32'h1);
        bus_read(A_STAT, rd);
        chk("bounce_stat", rd, 32'h1);

        // Measure set latency, then replay identically with a W1C landing on the set edge.
        edge_run(1'b0, 0, lat1);
        chk("edge_latency_min", lat1 >= int'(DB_TICK) + 2, 1);
        chk("edge_latency_max", lat1 <= 3 * int'(DB_TICK), 1);
        if (lat1 >= 2) begin
            edge_run(1'b1, lat1 - 2, lat2);
            chk("coinc_irq_pre", IRQ, 0);
            cyc();
            chk("coinc_irq_post", IRQ, 1);
            bus_read(A_STAT, rd);
            chk("coinc_stat", rd, 32'h1);
            bus_write(A_STAT, 32'h1);
            chk("w1c_irq_same_edge", IRQ, 1);
            cyc();
            chk("w1c_irq_drop", IRQ, 0);
            bus_read(A_STAT, rd);
            chk("w1c_stat", rd, 32'h0);
        end

        // Falling edge sets nothing; re-raise to get IRQ high before the mid-test reset.
        SW[0] = 1'b0;
        repeat (3 * DB_TICK) cyc();
        bus_read(A_STAT, rd);
        chk("fall_no_stat", rd, 32'h0);
        SW[0] = 1'b1;
        repeat (3 * DB_TICK) cyc();
        chk("irq_reassert", IRQ, 1);
        bus_write(A_LEDS, 32'hFF);
        bus_write(A_HEX0, 32'h7F);
        bus_read(A_ID, rd);
        chk("id_before_rst", rd, ID_EXP);

        rst = 1'b1;
        CS = 1'b1; WEN = 1'b1; REN = 1'b1; Addr = A_LEDS; DataIn = 32'h55;
        cyc();
        rst = 1'b0;
        bus_idle();
        chk("midrst_dout", DataOut, 32'h0);
        chk("midrst_leds", LEDS, 0);
        chk("midrst_hex", HEX, 0);
        chk("midrst_irq", IRQ, 0);
        cyc();
        chk("midrst_write_dropped", LEDS, 0);
        chk("midrst_read_dropped", DataOut, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_v2.md
GPIO_V2 -- requirements
Module: gpio_v2

Interface
REQ-001 Parameter NUM_HEX, default 6, number of 7-segment digit registers (legal 1..8).
REQ-002 Parameter LED_W, default 8, LED output width (legal 1..32).
REQ-003 Parameter SW_W, default 10, switch input width (legal 1..32).
REQ-004 Parameter DB_TICK, default 16, clock cycles between debounce samples (legal >=2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 CS  input  1  chip select; bus access only while high.
REQ-008 REN  input  1  read enable, qualified by CS.
REQ-009 WEN  input  1  write enable, qualified by CS.
REQ-010 Addr  input  12  byte address, word aligned; Addr[1:0] ignored.
REQ-011 DataIn  input  32  write data.
REQ-012 DataOut  output  32  registered read data.
REQ-013 SW  input  SW_W  asynchronous switch inputs.
REQ-014 HEX  output  7*NUM_HEX  digit i segments at bits [7i+6:7i].
REQ-015 LEDS  output  LED_W  LED drive.
REQ-016 IRQ  output  1  level interrupt, high while any enabled status bit set.

Function
REQ-017 Map: 0x004 SW_DB (RO, debounced switches); 0x008 LEDS (RW); 0x00C+4i HEXi (RW, i<NUM_HEX); 0x040 IRQ_EN (RW, SW_W bits); 0x044 IRQ_STAT (RO, write-1-to-clear); 0x048 ID (RO, {8'h47, NUM_HEX[7:0], LED_W[7:0], SW_W[7:0]}).
REQ-018 Write when CS&WEN: register takes DataIn low bits of its width; upper bits ignored; unmapped or HEXi with i>=NUM_HEX write ignored.
REQ-019 Read when CS&REN: DataOut updated at next clock edge with register value zero-extended; unmapped read returns 0.
REQ-020 DataOut holds last value when no read is in progress.
REQ-021 CS&REN&WEN same cycle: write applied, DataOut returns pre-write value.
REQ-022 SW passes through 2-flop synchroniser before any use.
REQ-023 Free-running tick counter pulses once every DB_TICK cycles; wraps DB_TICK-1 -> 0.
REQ-024 On each tick, SW_DB bit updates to synchronised value only if that value equalled the value sampled at the previous tick; otherwise unchanged.
REQ-025 Rising edge of any SW_DB bit (0->1) sets corresponding IRQ_STAT bit regardless of IRQ_EN.
REQ-026 IRQ_STAT bit set event and W1C of same bit in same cycle: set wins.
REQ-027 IRQ = |(IRQ_STAT & IRQ_EN), registered, asserted one cycle after status/enable change.
REQ-028 Switch bounce shorter than DB_TICK cycles never alters SW_DB.

Reset
REQ-029 On rst: LEDS, all HEXi, IRQ_EN, IRQ_STAT, SW_DB, sample history, synchroniser, tick counter, DataOut, IRQ all 0.
REQ-030 rst overrides a simultaneous bus write; pending read result discarded.
REQ-031 First debounced update occurs no earlier than 2*DB_TICK cycles after rst deasserts.

Structure
REQ-032 Package gpio_v2_pkg holds register offset constants and ID signature byte.
REQ-033 Sub-module gpio_debounce (synchroniser, tick counter, two-sample filter, edge pulse output), parametrised by SW_W and DB_TICK.

Verification
REQ-034 Reset, then write 0x0000_00A5 to 0x008 -> LEDS=0xA5; read 0x008 -> DataOut=0x0000_00A5 one cycle later.
REQ-035 Write 0x7F to 0x00C+4*5 with NUM_HEX=6 -> HEX[41:35]=0x7F; write to 0x00C+4*6 -> no output change, read returns 0.
REQ-036 SW[0] held 1 for 3*DB_TICK cycles -> SW_DB[0]=1, IRQ_STAT[0]=1; IRQ stays 0 until IRQ_EN=0x1 written, then 1 next cycle.
REQ-037 SW[1] toggled every 3 cycles with DB_TICK=16 -> SW_DB[1] stays 0, IRQ_STAT unchanged.
REQ-038 Write 0x1 to 0x044 coincident with new SW_DB[0] rising edge -> IRQ_STAT[0] remains 1; clean W1C alone -> 0, IRQ drops next cycle.
REQ-039 Read 0x048 with defaults -> DataOut=0x4706_080A; assert rst mid-test -> all outputs 0 next cycle.
